// File: rtl/game_pkg.sv
// Shared constants, state encoding and bus payload types for the breakout game.
// The block geometry values are defaults; block_field overrides them by parameter.
package game_pkg;

  localparam int unsigned SCREEN_W = 640;
  localparam int unsigned SCREEN_H = 480;
  localparam int unsigned COORD_W  = 10;

  localparam int unsigned DEF_NUM_BLOCKS  = 10;
  localparam int unsigned DEF_BLOCK_X0    = 0;
  localparam int unsigned DEF_BLOCK_PITCH = 64;
  localparam int unsigned DEF_BLOCK_W     = 60;
  localparam int unsigned DEF_BLOCK_TOP   = 40;
  localparam int unsigned DEF_BLOCK_H     = 20;

  localparam logic [23:0] DEF_BLOCK_COLOR = 24'hFF4000;
  localparam logic [23:0] COLOR_BLACK     = 24'h000000;

  typedef enum logic [1:0] {
    PLAY    = 2'd0,
    HIT     = 2'd1,
    CLEARED = 2'd2
  } state_t;

  // Axis-aligned rectangle as published by the ball
  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } rect_t;

endpackage

// File: rtl/block_overlap.sv
// Combinational rectangle-vs-block overlap test. Sums are 11 bits wide so an
// object near the right or bottom screen edge cannot wrap into a false result.
module block_overlap
  import game_pkg::*;
#(
  parameter int unsigned BX = DEF_BLOCK_X0,
  parameter int unsigned BY = DEF_BLOCK_TOP,
  parameter int unsigned BW = DEF_BLOCK_W,
  parameter int unsigned BH = DEF_BLOCK_H
) (
  input  logic [9:0] obj_x,
  input  logic [9:0] obj_y,
  input  logic [9:0] obj_w,
  input  logic [9:0] obj_h,
  output logic       overlap_c
);

  localparam logic [10:0] LEFT   = 11'(BX);
  localparam logic [10:0] RIGHT  = 11'(BX + BW);
  localparam logic [10:0] TOP    = 11'(BY);
  localparam logic [10:0] BOTTOM = 11'(BY + BH);

  logic [10:0] ox;
  logic [10:0] oy;
  logic [10:0] ox_end;
  logic [10:0] oy_end;

  assign ox     = {1'b0, obj_x};
  assign oy     = {1'b0, obj_y};
  assign ox_end = ox + {1'b0, obj_w};
  assign oy_end = oy + {1'b0, obj_h};

  assign overlap_c = (ox < RIGHT) && (ox_end > LEFT) &&
                     (oy < BOTTOM) && (oy_end > TOP);

endmodule

// File: rtl/block_field.sv
// Row of breakable blocks: collide responder for the ball, score keeping,
// field-cleared detection and the block layer of the VGA colour.
module block_field
  import game_pkg::*;
#(
  parameter int unsigned NUM_BLOCKS  = DEF_NUM_BLOCKS,
  parameter int unsigned BLOCK_X0    = DEF_BLOCK_X0,
  parameter int unsigned BLOCK_PITCH = DEF_BLOCK_PITCH,
  parameter int unsigned BLOCK_W     = DEF_BLOCK_W,
  parameter int unsigned BLOCK_TOP   = DEF_BLOCK_TOP,
  parameter int unsigned BLOCK_H     = DEF_BLOCK_H,
  parameter logic [23:0] BLOCK_COLOR = DEF_BLOCK_COLOR
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  restart,
  input  logic [9:0]            x,
  input  logic [9:0]            y,
  input  logic                  active_pixels,
  input  logic [9:0]            ball_x,
  input  logic [9:0]            ball_y,
  input  logic [9:0]            ball_width,
  input  logic [9:0]            ball_height,
  output logic [NUM_BLOCKS-1:0] collide_block,
  output logic [23:0]           vga_color,
  output logic                  block_pixel,
  output logic [NUM_BLOCKS-1:0] alive,
  output logic [3:0]            blocks_left,
  output logic [7:0]            score,
  output logic                  all_cleared
);

  state_t state;
  state_t state_d;

  rect_t ball_c;

  logic [NUM_BLOCKS-1:0] overlap_c;
  logic [NUM_BLOCKS-1:0] pixel_c;
  logic [NUM_BLOCKS-1:0] overlap_q;
  logic [NUM_BLOCKS-1:0] overlap_d;
  logic [NUM_BLOCKS-1:0] hit_c;
  logic [NUM_BLOCKS-1:0] pick_c;
  logic [NUM_BLOCKS-1:0] alive_d;
  logic [NUM_BLOCKS-1:0] collide_d;
  logic [7:0]            score_d;
  logic [9:0]            lat_x;
  logic [9:0]            lat_y;
  logic [9:0]            lat_x_d;
  logic [9:0]            lat_y_d;
  logic [3:0]            left_d;
  logic                  cleared_d;
  logic                  moved_c;

  assign ball_c = '{x: ball_x, y: ball_y, w: ball_width, h: ball_height};

  // Each block is tested against the ball and against the current pixel (a 1x1 box)
  for (genvar i = 0; i < NUM_BLOCKS; i++) begin : g_blk
    localparam int unsigned BX = BLOCK_X0 + i * BLOCK_PITCH;

    block_overlap #(
      .BX(BX), .BY(BLOCK_TOP), .BW(BLOCK_W), .BH(BLOCK_H)
    ) u_ball (
      .obj_x     (ball_c.x),
      .obj_y     (ball_c.y),
      .obj_w     (ball_c.w),
      .obj_h     (ball_c.h),
      .overlap_c (overlap_c[i])
    );

    block_overlap #(
      .BX(BX), .BY(BLOCK_TOP), .BW(BLOCK_W), .BH(BLOCK_H)
    ) u_pix (
      .obj_x     (x),
      .obj_y     (y),
      .obj_w     (10'd1),
      .obj_h     (10'd1),
      .overlap_c (pixel_c[i])
    );
  end

  assign hit_c   = overlap_q & alive;
  assign moved_c = (ball_x != lat_x) || (ball_y != lat_y);

  // Only the lowest-index hit is serviced; others wait for the next PLAY cycle
  always_comb begin
    pick_c = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      if (hit_c[i] && (pick_c == '0)) begin
        pick_c[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state;
    alive_d   = alive;
    collide_d = collide_block;
    score_d   = score;
    lat_x_d   = lat_x;
    lat_y_d   = lat_y;
    overlap_d = overlap_c;

    if (restart) begin
      state_d   = PLAY;
      alive_d   = '1;
      collide_d = '0;
      score_d   = '0;
      overlap_d = '0;
    end else begin
      case (state)
        PLAY: begin
          if (hit_c != '0) begin
            collide_d = pick_c;
            alive_d   = alive & ~pick_c;
            score_d   = (score == 8'hFF) ? score : score + 8'd1;
            lat_x_d   = ball_x;
            lat_y_d   = ball_y;
            state_d   = HIT;
          end
        end
        HIT: begin
          // Held until the ball has moved, so its slow tick is sure to see it
          if (moved_c) begin
            collide_d = '0;
            state_d   = (alive == '0) ? CLEARED : PLAY;
          end
        end
        CLEARED: begin
          collide_d = '0;
        end
        default: begin
          collide_d = '0;
          state_d   = PLAY;
        end
      endcase
    end

    left_d = '0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      left_d = left_d + {3'b000, alive_d[i]};
    end
    cleared_d = (state_d == CLEARED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= PLAY;
      alive         <= '1;
      collide_block <= '0;
      score         <= '0;
      blocks_left   <= 4'(NUM_BLOCKS);
      all_cleared   <= 1'b0;
      lat_x         <= '0;
      lat_y         <= '0;
      overlap_q     <= '0;
    end else begin
      state         <= state_d;
      alive         <= alive_d;
      collide_block <= collide_d;
      score         <= score_d;
      blocks_left   <= left_d;
      all_cleared   <= cleared_d;
      lat_x         <= lat_x_d;
      lat_y         <= lat_y_d;
      overlap_q     <= overlap_d;
    end
  end

  assign block_pixel = active_pixels && ((pixel_c & alive) != '0);
  assign vga_color   = block_pixel ? BLOCK_COLOR : COLOR_BLACK;

endmodule
